// File: rtl/pwrmgr_sync_filter_pkg.sv
// Shared constants and sizing helpers for the pwrmgr input synchronisers.
package pwrmgr_sync_filter_pkg;

    parameter int unsigned PwrSyncStages       = 2;
    parameter int unsigned PwrAstStableCycles  = 3;
    parameter logic [7:0]  PwrAstRspSyncDefault = 8'h00;

    // Width of a counter that must hold values 0..n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pwrmgr_sync_filter_if.sv
// Signal bundle between an asynchronous source and the pwrmgr sync filter.
interface pwrmgr_sync_filter_if #(
    parameter int unsigned Width  = 8,
    parameter int unsigned NumTgl = 1,
    parameter int unsigned DataW  = 4
);
    logic                    filter_en_i;
    logic [Width-1:0]        lvl_i;
    logic [Width-1:0]        lvl_o;
    logic                    lvl_chg_o;
    logic                    unstable_o;
    logic [NumTgl-1:0]       tgl_i;
    logic [NumTgl*DataW-1:0] tgl_data_i;
    logic [NumTgl-1:0]       tgl_pulse_o;
    logic [NumTgl*DataW-1:0] tgl_data_o;

    modport master (
        output filter_en_i, lvl_i, tgl_i, tgl_data_i,
        input  lvl_o, lvl_chg_o, unstable_o, tgl_pulse_o, tgl_data_o
    );

    modport slave (
        input  filter_en_i, lvl_i, tgl_i, tgl_data_i,
        output lvl_o, lvl_chg_o, unstable_o, tgl_pulse_o, tgl_data_o
    );
endinterface

// File: rtl/pwrmgr_sync_filter_tgl.sv
// Single toggle channel: synchroniser, delay flop, edge pulse and payload capture.
module pwrmgr_sync_filter_tgl #(
    parameter int unsigned NumStages = 2,
    parameter int unsigned DataW     = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tgl_i,
    input  logic [DataW-1:0] data_i,
    output logic             pulse_o,
    output logic [DataW-1:0] data_o
);
    logic [NumStages-1:0] sync_q;
    logic                 q2_q;
    logic [DataW-1:0]     data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            q2_q   <= 1'b0;
            data_q <= '0;
        end else begin
            sync_q <= {sync_q[NumStages-2:0], tgl_i};
            q2_q   <= sync_q[NumStages-1];
            if (pulse_o) begin
                data_q <= data_i;
            end
        end
    end

    assign pulse_o = sync_q[NumStages-1] ^ q2_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pwrmgr_sync_filter.sv
// Level-group synchroniser with stability filter and timeout, plus toggle-to-pulse channels.
module pwrmgr_sync_filter
    import pwrmgr_sync_filter_pkg::*;
#(
    parameter int unsigned      Width         = 8,
    parameter int unsigned      NumStages     = PwrSyncStages,
    parameter int unsigned      StableCycles  = 1,
    parameter int unsigned      TimeoutCycles = 0,
    parameter logic [Width-1:0] ResetValue    = '0,
    parameter int unsigned      NumTgl        = 1,
    parameter int unsigned      DataW         = 4
) (
    input logic               clk_i,
    input logic               rst_ni,
    pwrmgr_sync_filter_if.slave bus
);
    localparam int unsigned CntW  = cnt_width(StableCycles);
    localparam int unsigned TcntW = cnt_width(TimeoutCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

    logic [Width-1:0] sync_q [NumStages];
    logic [Width-1:0] sync;
    logic [Width-1:0] cand_q;
    logic [Width-1:0] lvl_q, lvl_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             chg_q, chg_d;
    logic             unstable;

    assign sync = sync_q[NumStages-1];

    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (!bus.filter_en_i) begin
            cnt_d = '0;
            lvl_d = sync;
        end else if (sync != cand_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                lvl_d = cand_q;
            end
        end
        chg_d = (lvl_d != lvl_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumStages); i++) begin
                sync_q[i] <= ResetValue;
            end
            cand_q <= ResetValue;
            lvl_q  <= ResetValue;
            cnt_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            sync_q[0] <= bus.lvl_i;
            for (int i = 1; i < int'(NumStages); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            cand_q <= sync;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            chg_q  <= chg_d;
        end
    end

    if (TimeoutCycles > 0) begin : g_timeout
        logic [TcntW-1:0] tcnt_q, tcnt_d;
        logic             unstable_q, unstable_d;

        // The flag latches until the synced input agrees with the filtered output again.
        always_comb begin
            tcnt_d     = tcnt_q;
            unstable_d = unstable_q;
            if (!bus.filter_en_i || sync == lvl_q) begin
                tcnt_d     = '0;
                unstable_d = 1'b0;
            end else begin
                if (tcnt_q != TcntW'(TimeoutCycles)) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                unstable_d = unstable_q || (tcnt_q == TcntW'(TimeoutCycles - 1));
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                tcnt_q     <= '0;
                unstable_q <= 1'b0;
            end else begin
                tcnt_q     <= tcnt_d;
                unstable_q <= unstable_d;
            end
        end

        assign unstable = unstable_q;
    end else begin : g_no_timeout
        assign unstable = 1'b0;
    end

    logic [NumTgl-1:0]       tgl_pulse;
    logic [NumTgl*DataW-1:0] tgl_data;

    for (genvar i = 0; i < int'(NumTgl); i++) begin : g_tgl
        pwrmgr_sync_filter_tgl #(
            .NumStages (NumStages),
            .DataW     (DataW)
        ) u_tgl (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .tgl_i   (bus.tgl_i[i]),
            .data_i  (bus.tgl_data_i[i*DataW +: DataW]),
            .pulse_o (tgl_pulse[i]),
            .data_o  (tgl_data[i*DataW +: DataW])
        );
    end

    assign bus.lvl_o       = lvl_q;
    assign bus.lvl_chg_o   = chg_q;
    assign bus.unstable_o  = unstable;
    assign bus.tgl_pulse_o = tgl_pulse;
    assign bus.tgl_data_o  = tgl_data;
endmodule

// File: tb/tb_pwrmgr_sync_filter.sv
// Directed bench: filter latency, glitch rejection, timeout, bypass, toggles and reset.
module tb_pwrmgr_sync_filter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pwrmgr_sync_filter_if #(.Width(8), .NumTgl(2), .DataW(4)) bus ();

    pwrmgr_sync_filter #(
        .Width         (8),
        .NumStages     (2),
        .StableCycles  (3),
        .TimeoutCycles (8),
        .ResetValue    (8'h00),
        .NumTgl        (2),
        .DataW         (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One destination edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.filter_en_i = 1'b1;
        bus.lvl_i       = 8'h00;
        bus.tgl_i       = 2'b00;
        bus.tgl_data_i  = 8'h00;
        #12;
        check("rst_lvl", 32'(bus.lvl_o), 32'h00);
        check("rst_chg", 32'(bus.lvl_chg_o), 32'h0);
        check("rst_unstable", 32'(bus.unstable_o), 32'h0);
        check("rst_pulse", 32'(bus.tgl_pulse_o), 32'h0);
        check("rst_tdata", 32'(bus.tgl_data_o), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();

        // Stable step: visible at edge 6 with a one-cycle change pulse.
        bus.lvl_i = 8'hA5;
        repeat (5) step();
        check("step_lvl_e5", 32'(bus.lvl_o), 32'h00);
        check("step_chg_e5", 32'(bus.lvl_chg_o), 32'h0);
        step();
        check("step_lvl_e6", 32'(bus.lvl_o), 32'hA5);
        check("step_chg_e6", 32'(bus.lvl_chg_o), 32'h1);
        step();
        check("step_chg_e7", 32'(bus.lvl_chg_o), 32'h0);
        check("step_lvl_e7", 32'(bus.lvl_o), 32'hA5);

        bus.lvl_i = 8'h00;
        repeat (6) step();
        check("back_lvl", 32'(bus.lvl_o), 32'h00);
        check("back_chg", 32'(bus.lvl_chg_o), 32'h1);
        repeat (4) step();

        // Two-cycle glitch must be rejected.
        bus.lvl_i = 8'h0F;
        repeat (2) step();
        bus.lvl_i = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            check("glitch_lvl", 32'(bus.lvl_o), 32'h00);
            check("glitch_chg", 32'(bus.lvl_chg_o), 32'h0);
        end

        // Alternating input never settles: timeout after 8 mismatched edges.
        for (int k = 1; k <= 9; k++) begin
            bus.lvl_i = (k % 2 == 1) ? 8'h01 : 8'h02;
            step();
        end
        check("alt_unstable_e9", 32'(bus.unstable_o), 32'h0);
        check("alt_lvl_e9", 32'(bus.lvl_o), 32'h00);
        bus.lvl_i = 8'h02;
        step();
        check("alt_unstable_e10", 32'(bus.unstable_o), 32'h1);
        bus.lvl_i = 8'h00;
        step();
        check("alt_unstable_e11", 32'(bus.unstable_o), 32'h1);
        step();
        check("alt_unstable_e12", 32'(bus.unstable_o), 32'h1);
        step();
        check("alt_unstable_e13", 32'(bus.unstable_o), 32'h0);
        check("alt_lvl_e13", 32'(bus.lvl_o), 32'h00);
        repeat (4) step();

        // Bypass: lvl_o follows sync after NumStages+1 edges.
        bus.filter_en_i = 1'b0;
        step();
        bus.lvl_i = 8'h3C;
        repeat (2) step();
        check("byp_lvl_e2", 32'(bus.lvl_o), 32'h00);
        step();
        check("byp_lvl_e3", 32'(bus.lvl_o), 32'h3C);
        check("byp_chg_e3", 32'(bus.lvl_chg_o), 32'h1);
        check("byp_unstable", 32'(bus.unstable_o), 32'h0);
        step();
        check("byp_chg_e4", 32'(bus.lvl_chg_o), 32'h0);
        bus.filter_en_i = 1'b1;
        repeat (3) step();
        check("reen_lvl", 32'(bus.lvl_o), 32'h3C);
        check("reen_chg", 32'(bus.lvl_chg_o), 32'h0);

        // Simultaneous toggles on both channels.
        bus.tgl_data_i = 8'hA5;
        bus.tgl_i      = 2'b11;
        step();
        check("tgl_pulse_e1", 32'(bus.tgl_pulse_o), 32'h0);
        step();
        check("tgl_pulse_e2", 32'(bus.tgl_pulse_o), 32'h3);
        check("tgl_data_e2", 32'(bus.tgl_data_o), 32'h00);
        step();
        check("tgl_pulse_e3", 32'(bus.tgl_pulse_o), 32'h0);
        check("tgl_data_e3", 32'(bus.tgl_data_o), 32'hA5);
        step();
        check("tgl_pulse_e4", 32'(bus.tgl_pulse_o), 32'h0);

        // Reset in the middle of a filter count (cnt=1 after edge 4).
        bus.lvl_i = 8'h11;
        repeat (4) step();
        check("mid_lvl", 32'(bus.lvl_o), 32'h3C);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_lvl", 32'(bus.lvl_o), 32'h00);
        check("mrst_unstable", 32'(bus.unstable_o), 32'h0);
        check("mrst_chg", 32'(bus.lvl_chg_o), 32'h0);
        check("mrst_tdata", 32'(bus.tgl_data_o), 32'h00);
        bus.lvl_i = 8'h00;
        bus.tgl_i = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("post_chg", 32'(bus.lvl_chg_o), 32'h0);
            check("post_pulse", 32'(bus.tgl_pulse_o), 32'h0);
            check("post_lvl", 32'(bus.lvl_o), 32'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
